// File: rtl/dma_engine.sv
// Bus-master copy/fill engine for main RAM: steals the RAM port by stalling the CPU,
// moves or fills a block byte by byte, then hands the bus back and flags DONE.
module dma_engine (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        R_W_n,
  input  logic [2:0]  reg_addr_i,
  input  logic [2:0]  reg_addr_r_i,
  input  logic [7:0]  data_i,
  input  logic        dma_cs,
  output logic [7:0]  data_o,
  input  logic        cpu_we_i,
  output logic        rdy_o,
  output logic        bus_grant_o,
  output logic [15:0] dma_addr_o,
  output logic [7:0]  dma_data_o,
  output logic        dma_we_o,
  input  logic [7:0]  dma_data_i,
  output logic        irq_o
);

  // state   | meaning
  // IDLE    | CPU owns RAM, registers writable
  // REQ     | CPU stalled, waiting for a non-write CPU cycle
  // RD      | source address on RAM port
  // LAT     | RAM read latency, capture byte
  // WR      | write byte to destination, step pointers
  // REL     | bus returned, CPU held one more cycle to re-read
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_RD   = 3'd2;
  localparam logic [2:0] ST_LAT  = 3'd3;
  localparam logic [2:0] ST_WR   = 3'd4;
  localparam logic [2:0] ST_REL  = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] len_q, len_d;
  logic        fill_mode_q, fill_mode_d;
  logic        irq_en_q, irq_en_d;
  logic [7:0]  fill_byte_q, fill_byte_d;
  logic [7:0]  rd_byte_q, rd_byte_d;
  logic        done_q, done_d;
  logic        busy;
  logic        reg_we;

  assign busy   = (state_q != ST_IDLE);
  assign reg_we = dma_cs && !R_W_n && !busy;

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    fill_mode_d = fill_mode_q;
    irq_en_d    = irq_en_q;
    fill_byte_d = fill_byte_q;
    rd_byte_d   = rd_byte_q;
    done_d      = done_q;
    case (state_q)
      ST_IDLE: begin
        if (reg_we) begin
          case (reg_addr_i)
            3'd0: src_d[7:0]  = data_i;
            3'd1: src_d[15:8] = data_i;
            3'd2: dst_d[7:0]  = data_i;
            3'd3: dst_d[15:8] = data_i;
            3'd4: len_d[7:0]  = data_i;
            3'd5: len_d[15:8] = data_i;
            3'd6: begin
              fill_mode_d = data_i[1];
              irq_en_d    = data_i[2];
              if (data_i[7]) done_d = 1'b0;
              // zero-length START completes immediately without touching the bus
              if (data_i[0]) begin
                done_d = (len_q == 16'd0);
                if (len_q != 16'd0) state_d = ST_REQ;
              end
            end
            default: fill_byte_d = data_i;
          endcase
        end
      end
      ST_REQ: begin
        if (!cpu_we_i) state_d = fill_mode_q ? ST_WR : ST_RD;
      end
      ST_RD:  state_d = ST_LAT;
      ST_LAT: begin
        rd_byte_d = dma_data_i;
        state_d   = ST_WR;
      end
      ST_WR: begin
        src_d = src_q + 16'd1;
        dst_d = dst_q + 16'd1;
        len_d = len_q - 16'd1;
        if (len_q == 16'd1) state_d = ST_REL;
        else                state_d = fill_mode_q ? ST_WR : ST_RD;
      end
      ST_REL: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      src_q       <= 16'd0;
      dst_q       <= 16'd0;
      len_q       <= 16'd0;
      fill_mode_q <= 1'b0;
      irq_en_q    <= 1'b0;
      fill_byte_q <= 8'd0;
      rd_byte_q   <= 8'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      fill_mode_q <= fill_mode_d;
      irq_en_q    <= irq_en_d;
      fill_byte_q <= fill_byte_d;
      rd_byte_q   <= rd_byte_d;
      done_q      <= done_d;
    end
  end

  assign rdy_o       = !busy;
  assign bus_grant_o = (state_q == ST_RD) || (state_q == ST_LAT) || (state_q == ST_WR);
  assign dma_we_o    = (state_q == ST_WR);
  assign irq_o       = done_q & irq_en_q;

  always_comb begin
    dma_addr_o = 16'd0;
    dma_data_o = 8'd0;
    if (state_q == ST_RD || state_q == ST_LAT) begin
      dma_addr_o = src_q;
    end else if (state_q == ST_WR) begin
      dma_addr_o = dst_q;
      dma_data_o = fill_mode_q ? fill_byte_q : rd_byte_q;
    end
  end

  always_comb begin
    case (reg_addr_r_i)
      3'd0:    data_o = src_q[7:0];
      3'd1:    data_o = src_q[15:8];
      3'd2:    data_o = dst_q[7:0];
      3'd3:    data_o = dst_q[15:8];
      3'd4:    data_o = len_q[7:0];
      3'd5:    data_o = len_q[15:8];
      3'd6:    data_o = {done_q, 4'b0000, irq_en_q, fill_mode_q, busy};
      default: data_o = fill_byte_q;
    endcase
  end

endmodule

// File: tb/tb_dma_engine.sv
// Directed bench for dma_engine with a behavioural 64 KiB RAM shared by a simple CPU model.
module tb_dma_engine;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        R_W_n;
  logic [2:0]  reg_addr_i;
  logic [2:0]  reg_addr_r_i;
  logic [7:0]  data_i;
  logic        dma_cs;
  logic [7:0]  data_o;
  logic        cpu_we_i;
  logic        rdy_o;
  logic        bus_grant_o;
  logic [15:0] dma_addr_o;
  logic [7:0]  dma_data_o;
  logic        dma_we_o;
  logic [7:0]  dma_data_i;
  logic        irq_o;

  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  mem [0:65535];
  int          dma_wr_cnt;
  int          n_cmp;
  int          n_bad;

  always #5 clk_i = ~clk_i;

  dma_engine dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .R_W_n(R_W_n), .reg_addr_i(reg_addr_i),
    .reg_addr_r_i(reg_addr_r_i), .data_i(data_i), .dma_cs(dma_cs), .data_o(data_o),
    .cpu_we_i(cpu_we_i), .rdy_o(rdy_o), .bus_grant_o(bus_grant_o), .dma_addr_o(dma_addr_o),
    .dma_data_o(dma_data_o), .dma_we_o(dma_we_o), .dma_data_i(dma_data_i), .irq_o(irq_o)
  );

  // RAM port muxed between CPU and engine, synchronous read
  always @(posedge clk_i) begin
    if (bus_grant_o && dma_we_o) begin
      mem[dma_addr_o] <= dma_data_o;
      dma_wr_cnt      <= dma_wr_cnt + 1;
    end else if (!bus_grant_o && cpu_we_i) begin
      mem[cpu_addr] <= cpu_wdata;
    end
    dma_data_i <= mem[bus_grant_o ? dma_addr_o : cpu_addr];
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk_i);
    dma_cs = 1'b1; R_W_n = 1'b0; reg_addr_i = a; data_i = d;
    @(negedge clk_i);
    dma_cs = 1'b0; R_W_n = 1'b1;
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
    reg_addr_r_i = a;
    #1;
    chk(tag, {8'h00, data_o}, {8'h00, exp});
  endtask

  task automatic setup(input logic [15:0] s, input logic [15:0] dd, input logic [15:0] l);
    reg_wr(3'd0, s[7:0]);  reg_wr(3'd1, s[15:8]);
    reg_wr(3'd2, dd[7:0]); reg_wr(3'd3, dd[15:8]);
    reg_wr(3'd4, l[7:0]);  reg_wr(3'd5, l[15:8]);
  endtask

  // counts rdy_o-low cycles and write cycles until the engine idles again
  task automatic run_to_idle(input string tag, output int busy_n, output int wr_n,
                             output int wr_first, output int wr_last);
    busy_n = 0; wr_n = 0; wr_first = -1; wr_last = -1;
    while (!rdy_o && busy_n < 2000) begin
      if (bus_grant_o && rdy_o) chk({tag, "_grant_rdy"}, 16'd1, 16'd0);
      if (dma_we_o) begin
        if (wr_first < 0) wr_first = busy_n;
        wr_last = busy_n;
        wr_n++;
      end
      busy_n++;
      @(negedge clk_i);
    end
    if (busy_n >= 2000) chk({tag, "_timeout"}, 16'd1, 16'd0);
  endtask

  int b, w, wf, wl, t;

  initial begin
    n_cmp = 0; n_bad = 0; dma_wr_cnt = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst_n_i = 1'b0; R_W_n = 1'b1; reg_addr_i = 3'd0; reg_addr_r_i = 3'd0;
    data_i = 8'h00; dma_cs = 1'b0; cpu_we_i = 1'b0; cpu_addr = 16'h0100; cpu_wdata = 8'h00;
    #1;
    chk("rst_rdy", {15'd0, rdy_o}, 16'd1);
    chk("rst_grant", {15'd0, bus_grant_o}, 16'd0);
    chk("rst_we", {15'd0, dma_we_o}, 16'd0);
    chk("rst_addr", dma_addr_o, 16'h0000);
    chk("rst_irq", {15'd0, irq_o}, 16'd0);
    chk_reg("rst_status", 3'd6, 8'h00);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;

    // 1: reset in the middle of a 256-byte copy
    for (int i = 0; i < 256; i++) mem[16'h1000 + i] = 8'(i + 1);
    setup(16'h1000, 16'h8000, 16'h0100);
    reg_wr(3'd6, 8'h01);
    t = 0;
    while (dma_wr_cnt < 10 && t < 500) begin @(negedge clk_i); t++; end
    chk("t1_reach10", {15'd0, (t < 500)}, 16'd1);
    rst_n_i = 1'b0;
    #1;
    chk("t1_rdy", {15'd0, rdy_o}, 16'd1);
    chk("t1_grant", {15'd0, bus_grant_o}, 16'd0);
    chk("t1_we", {15'd0, dma_we_o}, 16'd0);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (30) @(negedge clk_i);
    chk("t1_wrcnt", 16'(dma_wr_cnt), 16'd10);
    chk("t1_byte9", {8'h00, mem[16'h8009]}, 16'h000A);
    chk("t1_byte10", {8'h00, mem[16'h800A]}, 16'h0000);
    chk_reg("t1_len_l", 3'd4, 8'h00);

    // 2: 4-byte copy
    mem[16'h2000] = 8'h11; mem[16'h2001] = 8'h22; mem[16'h2002] = 8'h33; mem[16'h2003] = 8'h44;
    setup(16'h2000, 16'h3000, 16'h0004);
    reg_wr(3'd6, 8'h01);
    chk_reg("t2_busy", 3'd6, 8'h01);
    run_to_idle("t2", b, w, wf, wl);
    chk("t2_busy_cycles", 16'(b), 16'd14);
    chk("t2_wr_cycles", 16'(w), 16'd4);
    chk("t2_m0", {8'h00, mem[16'h3000]}, 16'h0011);
    chk("t2_m1", {8'h00, mem[16'h3001]}, 16'h0022);
    chk("t2_m2", {8'h00, mem[16'h3002]}, 16'h0033);
    chk("t2_m3", {8'h00, mem[16'h3003]}, 16'h0044);
    chk_reg("t2_status", 3'd6, 8'h80);
    chk_reg("t2_src_l", 3'd0, 8'h04);
    chk_reg("t2_src_h", 3'd1, 8'h20);
    chk_reg("t2_dst_l", 3'd2, 8'h04);
    chk_reg("t2_len_l", 3'd4, 8'h00);
    chk_reg("t2_len_h", 3'd5, 8'h00);

    // 3: 3-byte fill
    mem[16'h4003] = 8'hEE;
    setup(16'h0000, 16'h4000, 16'h0003);
    reg_wr(3'd7, 8'hA5);
    reg_wr(3'd6, 8'h03);
    run_to_idle("t3", b, w, wf, wl);
    chk("t3_busy_cycles", 16'(b), 16'd5);
    chk("t3_wr_cycles", 16'(w), 16'd3);
    chk("t3_wr_span", 16'(wl - wf + 1), 16'd3);
    chk("t3_m0", {8'h00, mem[16'h4000]}, 16'h00A5);
    chk("t3_m2", {8'h00, mem[16'h4002]}, 16'h00A5);
    chk("t3_m3", {8'h00, mem[16'h4003]}, 16'h00EE);
    chk_reg("t3_status", 3'd6, 8'h82);
    chk_reg("t3_fill", 3'd7, 8'hA5);

    // 4: START during CPU write cycles
    setup(16'h0000, 16'h5000, 16'h0001);
    reg_wr(3'd7, 8'h77);
    cpu_addr = 16'h6000; cpu_wdata = 8'h99; cpu_we_i = 1'b1;
    reg_wr(3'd6, 8'h03);
    chk("t4_grant_c1", {15'd0, bus_grant_o}, 16'd0);
    chk("t4_rdy_c1", {15'd0, rdy_o}, 16'd0);
    @(negedge clk_i);
    chk("t4_grant_c2", {15'd0, bus_grant_o}, 16'd0);
    cpu_we_i = 1'b0;
    @(negedge clk_i);
    chk("t4_grant_c3", {15'd0, bus_grant_o}, 16'd1);
    chk("t4_we_c3", {15'd0, dma_we_o}, 16'd1);
    chk("t4_addr_c3", dma_addr_o, 16'h5000);
    run_to_idle("t4", b, w, wf, wl);
    chk("t4_cpu_write", {8'h00, mem[16'h6000]}, 16'h0099);
    chk("t4_dma_write", {8'h00, mem[16'h5000]}, 16'h0077);
    cpu_addr = 16'h0100;

    // 5: destination wraps FFFF -> 0000
    mem[16'h0000] = 8'h00; mem[16'hFFFF] = 8'h00; mem[16'h0001] = 8'hC3;
    setup(16'h0000, 16'hFFFF, 16'h0002);
    reg_wr(3'd7, 8'h5A);
    reg_wr(3'd6, 8'h03);
    run_to_idle("t5", b, w, wf, wl);
    chk("t5_mffff", {8'h00, mem[16'hFFFF]}, 16'h005A);
    chk("t5_m0000", {8'h00, mem[16'h0000]}, 16'h005A);
    chk("t5_m0001", {8'h00, mem[16'h0001]}, 16'h00C3);
    chk_reg("t5_dst_l", 3'd2, 8'h01);
    chk_reg("t5_dst_h", 3'd3, 8'h00);

    // 6: zero-length START, IRQ, DONE clear
    reg_wr(3'd6, 8'h80);
    chk_reg("t6_done_clr", 3'd6, 8'h00);
    t = dma_wr_cnt;
    reg_wr(3'd6, 8'h05);
    chk("t6_grant", {15'd0, bus_grant_o}, 16'd0);
    chk("t6_rdy", {15'd0, rdy_o}, 16'd1);
    chk_reg("t6_status", 3'd6, 8'h84);
    chk("t6_irq_on", {15'd0, irq_o}, 16'd1);
    reg_wr(3'd6, 8'h84);
    #1;
    chk("t6_irq_off", {15'd0, irq_o}, 16'd0);
    chk_reg("t6_status2", 3'd6, 8'h04);
    chk("t6_no_writes", 16'(dma_wr_cnt - t), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
